// File: rtl/gmii_rx_axis_pkg.sv
// gmii_rx_axis_pkg: shared Ethernet framing constants, CRC-32 parameters and receive state encoding.
package gmii_rx_axis_pkg;
    localparam logic [7:0]  ETH_PRE    = 8'h55;
    localparam logic [7:0]  ETH_SFD    = 8'hD5;
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD} rx_state_t;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: one byte step of the reflected Ethernet CRC-32, LSB of the byte first.
module eth_crc32_d8
    import gmii_rx_axis_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    always_comb begin
        o_crc = i_crc ^ {24'd0, i_data};
        for (int i = 0; i < 8; i++)
            o_crc = o_crc[0] ? (o_crc >> 1) ^ CRC32_POLY_REFL : o_crc >> 1;
    end
endmodule

// File: rtl/gmii_rx_axis.sv
// gmii_rx_axis: GMII/MII receive framer; strips preamble, SFD and FCS and emits bytes as AXI-Stream with an error flag.
module gmii_rx_axis
    import gmii_rx_axis_pkg::*;
#(
    parameter int MIN_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic       clk_enable,
    input  logic       mii_select,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       start_packet,
    output logic       error_bad_frame,
    output logic       error_bad_fcs
);
    localparam int CW = $clog2(MIN_BYTES + 5);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_BYTES);
    localparam logic [CW-1:0] CNT_FULL = CW'(4);

    rx_state_t     r_state, w_next;
    logic [7:0]    r_rxd, r_pend, r_tdata, w_byte;
    logic          r_dv, r_er, r_half, r_bad, r_pend_v;
    logic [3:0]    r_lo;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_sr, r_crc, w_crc_nxt;
    logic          r_tvalid, r_tlast, r_tuser, r_start, r_err_frame, r_err_fcs;
    logic          w_sfd, w_acc, w_eof, w_short, w_bad, w_fcs_bad;

    // CRC covers only bytes leaving the FCS window, i.e. everything but the trailing four
    eth_crc32_d8 u_crc (.i_crc(r_crc), .i_data(r_sr[31:24]), .o_crc(w_crc_nxt));

    always_comb begin
        w_next = r_state;
        w_sfd  = 1'b0;
        w_acc  = 1'b0;
        w_eof  = 1'b0;
        case (r_state)
            ST_IDLE: w_next = r_dv ? ST_PREAMBLE : ST_IDLE;
            ST_PREAMBLE: begin
                w_sfd  = r_dv && (mii_select ? (r_lo == ETH_PRE[3:0] && r_rxd[3:0] == ETH_SFD[7:4])
                                             : r_rxd == ETH_SFD);
                w_next = !r_dv ? ST_IDLE : w_sfd ? ST_PAYLOAD : ST_PREAMBLE;
            end
            ST_PAYLOAD: begin
                w_eof  = !r_dv;
                w_acc  = r_dv && (!mii_select || r_half);
                w_next = r_dv ? ST_PAYLOAD : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        w_byte    = mii_select ? {r_rxd[3:0], r_lo} : r_rxd;
        w_short   = r_cnt < CNT_MAX;
        w_bad     = r_bad || r_half;
        w_fcs_bad = ~r_crc != {r_sr[7:0], r_sr[15:8], r_sr[23:16], r_sr[31:24]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rxd       <= '0;
            r_dv        <= 1'b0;
            r_er        <= 1'b0;
            r_lo        <= '0;
            r_half      <= 1'b0;
            r_bad       <= 1'b0;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            r_crc       <= CRC32_INIT;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_start     <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_fcs   <= 1'b0;
        end else begin
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_start     <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_fcs   <= 1'b0;
            if (clk_enable) begin
                r_rxd   <= gmii_rxd;
                r_dv    <= gmii_rx_dv;
                r_er    <= gmii_rx_er;
                r_state <= w_next;
                r_start <= w_sfd;
                if (r_state != ST_PAYLOAD) begin
                    r_lo     <= r_rxd[3:0];
                    r_half   <= 1'b0;
                    r_bad    <= (r_state == ST_PREAMBLE) && (r_bad || r_er);
                    r_cnt    <= '0;
                    r_sr     <= '0;
                    r_pend_v <= 1'b0;
                    r_crc    <= CRC32_INIT;
                end else begin
                    r_bad <= r_bad || r_er;
                    if (r_dv && mii_select) begin
                        r_half <= !r_half;
                        if (!r_half) r_lo <= r_rxd[3:0];
                    end
                    if (w_acc) begin
                        r_sr     <= {r_sr[23:0], w_byte};
                        r_cnt    <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                        r_tvalid <= r_pend_v;
                        r_tdata  <= r_pend;
                        if (r_cnt >= CNT_FULL) begin
                            r_pend   <= r_sr[31:24];
                            r_pend_v <= 1'b1;
                            r_crc    <= w_crc_nxt;
                        end
                    end
                    if (w_eof) begin
                        r_tvalid    <= !w_short;
                        r_tdata     <= r_pend;
                        r_tlast     <= !w_short;
                        r_tuser     <= !w_short && (w_bad || w_fcs_bad);
                        r_err_frame <= w_short || w_bad;
                        r_err_fcs   <= !w_short && w_fcs_bad;
                    end
                end
            end
        end
    end

    assign m_axis_tdata    = r_tdata;
    assign m_axis_tvalid   = r_tvalid;
    assign m_axis_tlast    = r_tlast;
    assign m_axis_tuser    = r_tuser;
    assign start_packet    = r_start;
    assign error_bad_frame = r_err_frame;
    assign error_bad_fcs   = r_err_fcs;
endmodule
